serial_sub64: RTL

- Multi-cycle unsigned subtractor: computes diff = a - b for WIDTH-bit operands, CHUNK bits per clock, with a registered borrow between chunks.
- Complements the combinational 2-bit-lookahead 64-bit adder chain, trading 32 cycles of latency for one small chunk subtractor.
- Sits beside the adder in the arithmetic lab datapath.
- Uses a start/busy/done handshake.

---
 rtl/serial_sub64.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_sub64.sv
// Multi-cycle unsigned subtractor: diff = a - b, CHUNK bits per clock with a
// registered borrow rippling between chunks. start/busy/done handshake.
module serial_sub64 #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] ra_chunk [STEPS];
  logic [CHUNK-1:0] rb_chunk [STEPS];
  logic [CHUNK:0]   sub_full;
  logic [CHUNK-1:0] sub_d;
  logic             sub_bout;
  logic [WIDTH-1:0] work_upd;

  // Slice the latched operands into chunks and merge the current chunk result
  // into the work register image.
  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_chunk
      assign ra_chunk[gi] = ra_q[gi*CHUNK +: CHUNK];
      assign rb_chunk[gi] = rb_q[gi*CHUNK +: CHUNK];
      assign work_upd[gi*CHUNK +: CHUNK] =
        (cnt_q == CNT_W'(gi)) ? sub_d : work_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // One extra bit of width: a negative chunk result wraps and sets the MSB.
  assign sub_full = {1'b0, ra_chunk[cnt_q]} - {1'b0, rb_chunk[cnt_q]}
                    - (CHUNK+1)'(borrow_q);
  assign sub_d    = sub_full[CHUNK-1:0];
  assign sub_bout = sub_full[CHUNK];

  always_comb begin
    state_d      = state_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    work_d       = work_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d     = a;
          rb_d     = b;
          work_d   = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        work_d   = work_upd;
        borrow_d = sub_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d        = '0;
          diff_d       = work_upd;
          borrow_out_d = sub_bout;
          zero_d       = (work_upd == '0);
          state_d      = DONE;
        end
      end
      // start is only sampled in IDLE, so DONE always falls back there first.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ra_q         <= '0;
      rb_q         <= '0;
      work_q       <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      work_q       <= work_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule
